// File: rtl/pipe_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Holds the access FSM encoding and the alignment helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam logic [31:0] WORD_MASK    = 32'h0000_0003;

    function automatic logic is_aligned(input logic [31:0] a);
        return (a & WORD_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles without a memory acknowledge.
// Saturates at TIMEOUT and flags the final allowed cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The current cycle is the TIMEOUT-th one once TIMEOUT-1 have elapsed.
    assign expired_o = (cnt_q >= (LIMIT - ONE));

    // Next count: clear wins, otherwise count up to LIMIT and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// Memory-stage data access controller feeding the MEM/WB register.
// Runs a req/ack data port, stalls the pipe, and aborts on timeout.
module mem_stage_access
    import pipe_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] Memout_o,
    output logic        stall_o,
    output logic        err_o
);

    mem_state_t  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] memout_q, memout_d;
    logic        err_q, err_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    // Timer restarts in IDLE and only runs in WAIT while unacknowledged.
    assign tmr_clr = (state_q == IDLE);
    assign tmr_en  = (state_q == WAIT) && !mem_ack_i;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    // Next-state, registered-output and stall logic for the access FSM.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        memout_d = memout_q;
        err_d    = err_q;
        stall_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemRead_i || MemWrite_i) begin
                    stall_o = 1'b1;
                    if (is_aligned(addr_i)) begin
                        we_d    = MemWrite_i;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        req_d   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        memout_d = ERR_DATA;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    if (!we_q) begin
                        memout_d = mem_rdata_i;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (tmr_expired) begin
                    if (!we_q) begin
                        memout_d = ERR_DATA;
                    end
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            memout_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            memout_q <= memout_d;
            err_q    <= err_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign Memout_o    = memout_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access.
// Hand-computed expectations, one checker task.
module tb_mem_stage_access;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, ack;
    logic [31:0] addr, wdata, rdata;
    logic        req, we, stall, err;
    logic [31:0] maddr, mwdata, memout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_access #(
        .TIMEOUT (TO),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (rd),
        .MemWrite_i (wr),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .mem_req_o  (req),
        .mem_we_o   (we),
        .mem_addr_o (maddr),
        .mem_wdata_o(mwdata),
        .mem_ack_i  (ack),
        .mem_rdata_i(rdata),
        .Memout_o   (memout),
        .stall_o    (stall),
        .err_o      (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sn;
        int nreq;
        logic [5:0] pat;

        rst = 1'b1; rd = 0; wr = 0; ack = 0;
        addr = '0; wdata = '0; rdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst req", req, 0);
        check("rst we", we, 0);
        check("rst addr", maddr, 0);
        check("rst wdata", mwdata, 0);
        check("rst memout", memout, 0);
        check("rst err", err, 0);
        check("rst stall", stall, 0);

        // load, ack in first WAIT cycle
        rd = 1; addr = 32'h10;
        #1;
        check("t1 stall0", stall, 1);
        check("t1 req0", req, 0);
        step();
        check("t1 req", req, 1);
        check("t1 addr", maddr, 32'h10);
        check("t1 we", we, 0);
        check("t1 stall1", stall, 1);
        ack = 1; rdata = 32'hCAFE_F00D;
        step();
        ack = 0; rdata = '0;
        #1;
        check("t1 done stall", stall, 0);
        check("t1 memout", memout, 32'hCAFE_F00D);
        check("t1 req drop", req, 0);
        step();
        rd = 0; addr = '0;
        #1;
        check("t1 idle stall", stall, 0);

        // store, ack on 5th WAIT cycle (also TIMEOUT-th)
        wr = 1; addr = 32'h20; wdata = 32'h1234_5678;
        #1;
        sn = stall ? 1 : 0;
        step();
        for (int i = 1; i <= 5; i++) begin
            check("t2 req", req, 1);
            check("t2 we", we, 1);
            check("t2 wdata", mwdata, 32'h1234_5678);
            if (stall) sn++;
            if (i == 5) ack = 1;
            #1;
            step();
        end
        ack = 0; wdata = '0;
        #1;
        check("t2 stall len", sn, 6);
        check("t2 done stall", stall, 0);
        check("t2 memout", memout, 32'hCAFE_F00D);
        check("t2 err", err, 0);
        step();
        wr = 0; addr = '0;

        // load never acknowledged
        rd = 1; addr = 32'h30; rdata = 32'h5555_5555;
        sn = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!stall) break;
            sn++;
            step();
        end
        check("t3 stall len", sn, TO + 1);
        check("t3 req", req, 0);
        check("t3 memout", memout, 32'hDEAD_BEEF);
        check("t3 err", err, 1);
        step();
        rd = 0;

        // good load afterwards, err stays sticky
        rd = 1; addr = 32'h44;
        #1;
        step();
        ack = 1; rdata = 32'hA5A5_A5A5;
        #1;
        step();
        ack = 0; rdata = '0;
        #1;
        check("t3b memout", memout, 32'hA5A5_A5A5);
        check("t3b err", err, 1);
        step();
        rd = 0;

        // read+write together, then reset during WAIT
        rd = 1; wr = 1; addr = 32'h40; wdata = 32'h0F0F_0F0F;
        #1;
        step();
        check("t5 we", we, 1);
        check("t5 req", req, 1);
        check("t5 addr", maddr, 32'h40);
        rst = 1;
        #1;
        step();
        rst = 0;
        #1;
        check("t5 rst req", req, 0);
        check("t5 rst memout", memout, 0);
        check("t5 rst err", err, 0);
        check("t5 rst we", we, 0);
        check("t5 stall act", stall, 1);
        rd = 0; wr = 0;
        #1;
        check("t5 stall idle", stall, 0);
        step();
        check("t5 stay idle", req, 0);

        // misaligned load
        rd = 1; addr = 32'h13;
        #1;
        check("t4 stall", stall, 1);
        check("t4 req0", req, 0);
        step();
        check("t4 done stall", stall, 0);
        check("t4 req1", req, 0);
        check("t4 memout", memout, 32'hDEAD_BEEF);
        check("t4 err", err, 1);
        step();
        rd = 0; addr = '0;
        #1;
        check("t4 req2", req, 0);

        // back-to-back loads, ack held high throughout
        rd = 1; addr = 32'h50; ack = 1; rdata = 32'h1111_1111;
        pat = '0;
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                addr = 32'h54;
                rdata = 32'h2222_2222;
            end
            #1;
            pat = {pat[4:0], stall};
            if (req) nreq++;
            if (c == 2) check("t6 memout a", memout, 32'h1111_1111);
            if (c == 5) check("t6 memout b", memout, 32'h2222_2222);
            step();
        end
        rd = 0; ack = 0;
        check("t6 pattern", pat, 6'b110110);
        check("t6 nreq", nreq, 2);
        check("t6 err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
